// File: rtl/shift_sub_signed_divider_pkg.sv
// Shared arithmetic-unit package: divider FSM encodings and counter sizing.
// Used by shift_sub_signed_divider, its interface and sub-modules.
package shift_arith_pkg;

  localparam int unsigned DIV_N = 32;
  localparam int unsigned CNT_W = $clog2(DIV_N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Counter width for an arbitrary operand width
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/shift_sub_signed_divider_if.sv
// Request/response bundle for the shift-subtract signed divider.
interface shift_sub_signed_divider_if #(
  parameter int unsigned N = shift_arith_pkg::DIV_N
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;
  logic         ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, ovf
  );
endinterface

// File: rtl/shift_sub_signed_divider_abs.sv
// Conditional two's-complement negator: out_val = neg ? -in_val : in_val.
module shift_div_abs #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] in_val,
  input  logic         neg,
  output logic [N-1:0] out_val
);
  assign out_val = neg ? N'(~in_val + N'(1)) : in_val;
endmodule

// File: rtl/shift_sub_signed_divider.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Optional early exception decode (div-by-zero, overflow) under SHIFT_DIV_EXCEPT_EN.
module shift_sub_signed_divider
  import shift_arith_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic                        clk,
  input  logic                        rst,
  shift_sub_signed_divider_if.slave   bus
);

  localparam int unsigned CW = cnt_width(N);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  rem_q, quo_q, dmag_q;
  logic          sdiff_q, dneg_q, dz_q, ov_q;

  logic [N-1:0]  a_mag, b_mag, quo_fix, rem_fix, diff;
  logic [N:0]    shifted;
  logic          ge_c, dz_c, ov_c, exc_c;

  shift_div_abs #(.N(N)) u_abs_a (.in_val(bus.dividend), .neg(bus.dividend[N-1]), .out_val(a_mag));
  shift_div_abs #(.N(N)) u_abs_b (.in_val(bus.divisor),  .neg(bus.divisor[N-1]),  .out_val(b_mag));
  shift_div_abs #(.N(N)) u_fix_q (.in_val(quo_q), .neg(sdiff_q), .out_val(quo_fix));
  shift_div_abs #(.N(N)) u_fix_r (.in_val(rem_q), .neg(dneg_q),  .out_val(rem_fix));

`ifdef SHIFT_DIV_EXCEPT_EN
  assign dz_c = (bus.divisor == '0);
  assign ov_c = (bus.dividend == {1'b1, {(N-1){1'b0}}}) && (bus.divisor == '1);
`else
  assign dz_c = 1'b0;
  assign ov_c = 1'b0;
`endif
  assign exc_c = dz_c | ov_c;

  // Trial subtraction of the divisor magnitude from the shifted partial remainder
  assign shifted = {rem_q, quo_q[N-1]};
  assign ge_c    = (shifted >= {1'b0, dmag_q});
  assign diff    = N'(shifted - {1'b0, dmag_q});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = exc_c ? DONE : CALC;
      CALC:    if (cnt_q == CW'(N - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture magnitudes, iterate, restore signs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      sdiff_q <= 1'b0;
      dneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          cnt_q   <= '0;
          dmag_q  <= b_mag;
          sdiff_q <= bus.dividend[N-1] ^ bus.divisor[N-1];
          dneg_q  <= bus.dividend[N-1];
          dz_q    <= dz_c;
          ov_q    <= ov_c;
          if (dz_c) begin
            quo_q <= bus.dividend[N-1] ? N'(1) : '1;
            rem_q <= bus.dividend;
          end else if (ov_c) begin
            quo_q <= {1'b1, {(N-1){1'b0}}};
            rem_q <= '0;
          end else begin
            quo_q <= a_mag;
            rem_q <= '0;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          rem_q <= ge_c ? diff : shifted[N-1:0];
          quo_q <= {quo_q[N-2:0], ge_c};
        end
        FIX: begin
          quo_q <= quo_fix;
          rem_q <= rem_fix;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: results publish together with the done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.busy <= (state_d != IDLE);
      bus.done <= (state_q == DONE);
      if (state_q == DONE) begin
        bus.quotient  <= quo_q;
        bus.remainder <= rem_q;
        bus.div_zero  <= dz_q;
        bus.ovf       <= ov_q;
      end
    end
  end

endmodule
